machine_timer: RTL and testbench
================================

MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 SHALL have parameter RESET_PRESCALE, default 16'd0, reset value of the PRESCALE register.
REQ-002 SHALL have parameter ADDR_LSB, default 2, lowest address bit used for register-offset decode.
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port read  input  1  bus read request, held high by the initiator until response is seen.
REQ-006 SHALL have port write  input  1  bus write request, held high by the initiator until response is seen.
REQ-007 SHALL have port address  input  32  byte address; offset = address[ADDR_LSB+2:ADDR_LSB].
REQ-008 SHALL have port write_data  input  32  full-word write data; no byte enables.
REQ-009 SHALL have port read_data  output  32  registered read result.
REQ-010 SHALL have port response  output  1  one-cycle completion strobe.
REQ-011 SHALL have port irq  output  1  registered timer interrupt, level.

Function
REQ-012 Register map by offset SHALL be: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 enable, bit1 irq_en), 5 PRESCALE (bits 15:0), 6-7 unmapped.
REQ-013 Handshake FSM SHALL have states IDLE, ACK, DRAIN.
REQ-014 IDLE: on read or write high, perform the access and go to ACK; read_data and response become valid the following cycle (latency 1).
REQ-015 ACK: response high for exactly one cycle, then go to DRAIN.
REQ-016 DRAIN: ignore requests; return to IDLE on the first cycle with read and write both low.
REQ-017 read and write both high in IDLE SHALL be treated as a write; read_data SHALL stay unchanged.
REQ-018 Unmapped reads SHALL return 32'h0; unmapped writes SHALL be ignored; both SHALL still complete with response.
REQ-019 read_data SHALL hold its last value outside read completions.
REQ-020 A read of MTIME_LO SHALL latch mtime[63:32] into a snapshot; a read of MTIME_HI SHALL return the snapshot, giving a coherent 64-bit read.
REQ-021 The prescale counter SHALL count 0..PRESCALE while enable=1; a tick SHALL fire on count==PRESCALE, and the counter SHALL then wrap to 0 (PRESCALE=0 -> tick every cycle).
REQ-022 On a tick, mtime SHALL increment by 1 and wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-023 enable=0 SHALL freeze mtime and hold the prescale counter at 0.
REQ-024 A bus write to MTIME_LO/HI in the same cycle as a tick SHALL take precedence: the written half takes write_data, the other half holds, and there is no increment that cycle.
REQ-025 A write to PRESCALE SHALL clear the prescale counter.
REQ-026 irq SHALL be registered as irq_en & (mtime >= mtimecmp), unsigned 64-bit compare, one cycle after the condition.
REQ-027 irq SHALL deassert one cycle after a write raising mtimecmp above mtime, or after irq_en is cleared.

Reset
REQ-028 Asserting reset (low) SHALL immediately force: mtime=0, snapshot=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=RESET_PRESCALE, prescale counter=0, FSM=IDLE, read_data=0, response=0, irq=0.
REQ-029 Reset mid-transaction SHALL drop response at once; after release, a still-high request SHALL be serviced as a new access from IDLE.

Structure
REQ-030 Register offsets, CTRL bit positions and FSM state encodings SHALL live in the shared peripheral package.
REQ-031 The 64-bit counter plus prescaler SHALL be a single sub-module, timer_counter, with tick, load-lo, load-hi and enable inputs.

Verification
REQ-032 Write CTRL=1, PRESCALE=0, run 10 cycles -> MTIME_LO reads approximately 10 (exact value per latency); response lasts exactly 1 cycle per access.
REQ-033 PRESCALE=3, enable -> mtime increments once every 4 cycles; write PRESCALE mid-count -> counter restarts at 0.
REQ-034 Write MTIME_HI=0, MTIME_LO=32'hFFFF_FFFE, enable -> read LO then HI returns 32'h0000_0000 / 32'h0000_0001 coherently, with no torn value.
REQ-035 MTIMECMP=20, CTRL=3 -> irq rises the cycle after mtime reaches 20; write MTIMECMP_LO=100 -> irq falls the next cycle.
REQ-036 Hold read high for 5 cycles -> exactly one response; offset 7 read -> 32'h0; read+write together -> write applied, read_data unchanged.
REQ-037 Assert reset during ACK -> response=0 immediately, mtimecmp=all-ones, irq=0.

Source files
------------

// File: rtl/machine_timer_pkg.sv
// Shared definitions for the machine timer peripheral: register offsets,
// CTRL bit positions, bus handshake states and a CTRL read-back helper.
package machine_timer_pkg;

   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;
   localparam logic [2:0] OFF_PRESCALE    = 3'd5;

   localparam logic [4:0] CTRL_ENABLE_BIT = 5'd0;
   localparam logic [4:0] CTRL_IRQ_EN_BIT = 5'd1;

   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACK   = 2'd1,
      ST_DRAIN = 2'd2
   } bus_state_e;

   function automatic logic [31:0] ctrl_word(input logic enable, input logic irq_en);
      logic [31:0] word;
      word                  = 32'd0;
      word[CTRL_ENABLE_BIT] = enable;
      word[CTRL_IRQ_EN_BIT] = irq_en;
      return word;
   endfunction

endpackage

// File: rtl/machine_timer_counter.sv
// 64-bit mtime counter advanced by a programmable prescaler; bus loads of
// either half win over a tick arriving in the same cycle.
module timer_counter
   import machine_timer_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic [15:0] prescale_i,
   input  logic        prescale_clr_i,
   input  logic        load_lo_i,
   input  logic        load_hi_i,
   input  logic [31:0] load_data_i,
   output logic [63:0] mtime_o
);

   logic [15:0] count_q, count_d;
   logic [63:0] mtime_q, mtime_d;
   logic        tick_s;

   // Prescaler and mtime next-state
   always_comb begin
      tick_s  = 1'b0;
      count_d = count_q;
      mtime_d = mtime_q;
      if (!enable_i) begin
         count_d = 16'd0;
      end else if (prescale_clr_i) begin
         count_d = 16'd0;
      end else if (count_q == prescale_i) begin
         tick_s  = 1'b1;
         count_d = 16'd0;
      end else begin
         count_d = count_q + 16'd1;
      end
      if (load_lo_i) begin
         mtime_d[31:0] = load_data_i;
      end else if (load_hi_i) begin
         mtime_d[63:32] = load_data_i;
      end else if (tick_s) begin
         mtime_d = mtime_q + 64'd1;
      end else begin
         mtime_d = mtime_q;
      end
   end

   // Counter state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= 16'd0;
         mtime_q <= 64'd0;
      end else begin
         count_q <= count_d;
         mtime_q <= mtime_d;
      end
   end

   assign mtime_o = mtime_q;

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: request/response bus handshake, mtime/mtimecmp
// registers with coherent 64-bit read via a high-half snapshot, level irq.
module machine_timer
   import machine_timer_pkg::*;
#(
   parameter logic [15:0] RESET_PRESCALE = 16'd0,
   parameter int          ADDR_LSB       = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        response,
   output logic        irq
);

   bus_state_e  state_q, state_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [31:0] snapshot_q, snapshot_d;
   logic [31:0] read_data_q, read_data_d;
   logic [15:0] prescale_q, prescale_d;
   logic        ctrl_en_q, ctrl_en_d;
   logic        ctrl_irq_en_q, ctrl_irq_en_d;
   logic        response_q, irq_q;

   logic [2:0]  offset_s;
   logic [63:0] mtime_s;
   logic        wr_s, rd_s, load_lo_s, load_hi_s, prescale_clr_s;
   logic        unused_addr_s;

   assign offset_s      = address[ADDR_LSB+2:ADDR_LSB];
   assign unused_addr_s = ^address;
   // A simultaneous read+write is serviced as a write only.
   assign wr_s = (state_q == ST_IDLE) && write;
   assign rd_s = (state_q == ST_IDLE) && read && !write;

   // Handshake next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (read || write) state_d = ST_ACK; else state_d = ST_IDLE;
         ST_ACK:   state_d = ST_DRAIN;
         ST_DRAIN: if (!read && !write) state_d = ST_IDLE; else state_d = ST_DRAIN;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Register write decode and read mux
   always_comb begin
      mtimecmp_d     = mtimecmp_q;
      snapshot_d     = snapshot_q;
      read_data_d    = read_data_q;
      prescale_d     = prescale_q;
      ctrl_en_d      = ctrl_en_q;
      ctrl_irq_en_d  = ctrl_irq_en_q;
      load_lo_s      = 1'b0;
      load_hi_s      = 1'b0;
      prescale_clr_s = 1'b0;
      if (wr_s) begin
         case (offset_s)
            OFF_MTIME_LO:    load_lo_s = 1'b1;
            OFF_MTIME_HI:    load_hi_s = 1'b1;
            OFF_MTIMECMP_LO: mtimecmp_d[31:0] = write_data;
            OFF_MTIMECMP_HI: mtimecmp_d[63:32] = write_data;
            OFF_CTRL: begin
               ctrl_en_d     = write_data[CTRL_ENABLE_BIT];
               ctrl_irq_en_d = write_data[CTRL_IRQ_EN_BIT];
            end
            OFF_PRESCALE: begin
               prescale_d     = write_data[15:0];
               prescale_clr_s = 1'b1;
            end
            default:         load_lo_s = 1'b0;
         endcase
      end else if (rd_s) begin
         case (offset_s)
            OFF_MTIME_LO: begin
               read_data_d = mtime_s[31:0];
               snapshot_d  = mtime_s[63:32];
            end
            OFF_MTIME_HI:    read_data_d = snapshot_q;
            OFF_MTIMECMP_LO: read_data_d = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: read_data_d = mtimecmp_q[63:32];
            OFF_CTRL:        read_data_d = ctrl_word(ctrl_en_q, ctrl_irq_en_q);
            OFF_PRESCALE:    read_data_d = {16'd0, prescale_q};
            default:         read_data_d = 32'd0;
         endcase
      end else begin
         read_data_d = read_data_q;
      end
   end

   timer_counter u_counter (
      .clk_i          (clk),
      .rst_ni         (reset),
      .enable_i       (ctrl_en_q),
      .prescale_i     (prescale_q),
      .prescale_clr_i (prescale_clr_s),
      .load_lo_i      (load_lo_s),
      .load_hi_i      (load_hi_s),
      .load_data_i    (write_data),
      .mtime_o        (mtime_s)
   );

   // Bus, configuration and interrupt registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         mtimecmp_q    <= MTIMECMP_RESET;
         snapshot_q    <= 32'd0;
         read_data_q   <= 32'd0;
         prescale_q    <= RESET_PRESCALE;
         ctrl_en_q     <= 1'b0;
         ctrl_irq_en_q <= 1'b0;
         response_q    <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         mtimecmp_q    <= mtimecmp_d;
         snapshot_q    <= snapshot_d;
         read_data_q   <= read_data_d;
         prescale_q    <= prescale_d;
         ctrl_en_q     <= ctrl_en_d;
         ctrl_irq_en_q <= ctrl_irq_en_d;
         response_q    <= wr_s || rd_s;
         irq_q         <= ctrl_irq_en_q && (mtime_s >= mtimecmp_q);
      end
   end

   assign read_data = read_data_q;
   assign response  = response_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: register table plus timing sequences for
// prescaling, coherent reads, irq edges, request holding and mid-access reset.
module tb_machine_timer;

   logic        clk, reset, read, write;
   logic [31:0] address, write_data, read_data;
   logic        response, irq;

   int errors = 0;
   int checks = 0;
   logic        last_irq_ack, last_irq_next;
   logic [31:0] d;
   int          resp_cnt;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  off;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[20];

   machine_timer #(.RESET_PRESCALE(16'd0), .ADDR_LSB(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .read       (read),
      .write      (write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .response   (response),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] off,
                               input logic [31:0] wdata, input logic [31:0] exp);
      vec_t v;
      v.rd = rd; v.wr = wr; v.off = off; v.wdata = wdata; v.exp = exp;
      return v;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Starts one access from IDLE; returns back in IDLE two cycles after the response.
   task automatic bus_access(input logic rd, input logic wr, input logic [2:0] off,
                             input logic [31:0] wdata, output logic [31:0] rdata);
      address    = 32'h4000_0000 | ({29'd0, off} << 2);
      write_data = wdata;
      read       = rd;
      write      = wr;
      @(posedge clk); #1;
      check1("resp_latency", response, 1'b1);
      for (int i = 0; i < 4 && response !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      rdata        = read_data;
      last_irq_ack = irq;
      read  = 1'b0;
      write = 1'b0;
      @(posedge clk); #1;
      check1("resp_one_cycle", response, 1'b0);
      last_irq_next = irq;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      read  = 1'b0;
      write = 1'b0;
      reset = 1'b0;
      #1;
      check32("rst_read_data", read_data, 32'h0);
      check1("rst_response", response, 1'b0);
      check1("rst_irq", irq, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0;
      address = 32'h0; write_data = 32'h0;
      #2;

      // Free-running count with PRESCALE=0
      do_reset();
      bus_access(1'b0, 1'b1, 3'd5, 32'h0, d);
      bus_access(1'b0, 1'b1, 3'd4, 32'h1, d);
      idle(8);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("mtime_after_10", d, 32'd10);
      bus_access(1'b1, 1'b0, 3'd1, 32'h0, d);
      check32("mtime_hi_zero", d, 32'd0);

      // PRESCALE=3 and restart on PRESCALE write
      do_reset();
      bus_access(1'b0, 1'b1, 3'd5, 32'd3, d);
      bus_access(1'b0, 1'b1, 3'd4, 32'd1, d);
      bus_access(1'b0, 1'b1, 3'd5, 32'd3, d);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("presc_restart", d, 32'd0);
      idle(6);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("presc_div4_a", d, 32'd2);
      idle(1);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("presc_div4_b", d, 32'd3);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("presc_div4_c", d, 32'd4);

      // Carry across the halves, coherent read, write beats tick
      do_reset();
      bus_access(1'b0, 1'b1, 3'd1, 32'h0, d);
      bus_access(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFE, d);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("frozen_lo", d, 32'hFFFF_FFFE);
      bus_access(1'b0, 1'b1, 3'd4, 32'h1, d);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("carry_lo", d, 32'h0000_0000);
      bus_access(1'b1, 1'b0, 3'd1, 32'h0, d);
      check32("carry_hi_snapshot", d, 32'h0000_0001);
      bus_access(1'b0, 1'b1, 3'd0, 32'h0000_0100, d);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("load_beats_tick", d, 32'h0000_0102);
      bus_access(1'b1, 1'b0, 3'd1, 32'h0, d);
      check32("load_keeps_hi", d, 32'h0000_0001);

      // Register table; every row also checks read_data holds across writes
      do_reset();
      vecs[0]  = mk(1'b1, 1'b0, 3'd4, 32'h0,         32'h0000_0000);
      vecs[1]  = mk(1'b1, 1'b0, 3'd5, 32'h0,         32'h0000_0000);
      vecs[2]  = mk(1'b1, 1'b0, 3'd2, 32'h0,         32'hFFFF_FFFF);
      vecs[3]  = mk(1'b1, 1'b0, 3'd3, 32'h0,         32'hFFFF_FFFF);
      vecs[4]  = mk(1'b0, 1'b1, 3'd2, 32'h1234_5678, 32'hFFFF_FFFF);
      vecs[5]  = mk(1'b1, 1'b0, 3'd2, 32'h0,         32'h1234_5678);
      vecs[6]  = mk(1'b0, 1'b1, 3'd3, 32'hABCD_0001, 32'h1234_5678);
      vecs[7]  = mk(1'b1, 1'b0, 3'd3, 32'h0,         32'hABCD_0001);
      vecs[8]  = mk(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'hABCD_0001);
      vecs[9]  = mk(1'b1, 1'b0, 3'd5, 32'h0,         32'h0000_BEEF);
      vecs[10] = mk(1'b0, 1'b1, 3'd4, 32'hFFFF_FFFC, 32'h0000_BEEF);
      vecs[11] = mk(1'b1, 1'b0, 3'd4, 32'h0,         32'h0000_0000);
      vecs[12] = mk(1'b0, 1'b1, 3'd6, 32'h5555_5555, 32'h0000_0000);
      vecs[13] = mk(1'b1, 1'b0, 3'd6, 32'h0,         32'h0000_0000);
      vecs[14] = mk(1'b1, 1'b0, 3'd7, 32'h0,         32'h0000_0000);
      vecs[15] = mk(1'b1, 1'b0, 3'd5, 32'h0,         32'h0000_BEEF);
      vecs[16] = mk(1'b1, 1'b1, 3'd4, 32'h0000_0002, 32'h0000_BEEF);
      vecs[17] = mk(1'b1, 1'b0, 3'd4, 32'h0,         32'h0000_0002);
      vecs[18] = mk(1'b1, 1'b0, 3'd0, 32'h0,         32'h0000_0000);
      vecs[19] = mk(1'b1, 1'b0, 3'd1, 32'h0,         32'h0000_0000);
      for (int i = 0; i < 20; i++) begin
         bus_access(vecs[i].rd, vecs[i].wr, vecs[i].off, vecs[i].wdata, d);
         check32($sformatf("vec%0d", i), d, vecs[i].exp);
      end

      // Request held for 5 cycles yields one response
      address  = 32'h4000_0000 | 32'h10;
      read     = 1'b1;
      resp_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (response === 1'b1) resp_cnt++;
      end
      read = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (response === 1'b1) resp_cnt++;
      end
      check32("held_read_responses", resp_cnt, 32'd1);

      // irq rise at mtime==mtimecmp, fall on raised compare and on irq_en clear
      do_reset();
      bus_access(1'b0, 1'b1, 3'd3, 32'h0, d);
      bus_access(1'b0, 1'b1, 3'd2, 32'd20, d);
      bus_access(1'b0, 1'b1, 3'd4, 32'd3, d);
      check1("irq_low_early", last_irq_next, 1'b0);
      idle(18);
      check1("irq_low_at_20", irq, 1'b0);
      idle(1);
      check1("irq_rise", irq, 1'b1);
      bus_access(1'b0, 1'b1, 3'd2, 32'd100, d);
      check1("irq_before_fall", last_irq_ack, 1'b1);
      check1("irq_fall_cmp", last_irq_next, 1'b0);
      bus_access(1'b0, 1'b1, 3'd2, 32'd5, d);
      check1("irq_rise_cmp5", last_irq_next, 1'b1);
      bus_access(1'b0, 1'b1, 3'd4, 32'd1, d);
      check1("irq_hold_ack", last_irq_ack, 1'b1);
      check1("irq_fall_en", last_irq_next, 1'b0);

      // Reset asserted during ACK, request still high afterwards
      bus_access(1'b0, 1'b1, 3'd4, 32'd3, d);
      check1("irq_reenabled", last_irq_next, 1'b1);
      address = 32'h4000_0000 | 32'h10;
      read    = 1'b1;
      @(posedge clk); #1;
      check1("ack_before_reset", response, 1'b1);
      check32("ctrl_before_reset", read_data, 32'd3);
      reset = 1'b0;
      #1;
      check1("reset_drops_resp", response, 1'b0);
      check1("reset_drops_irq", irq, 1'b0);
      check32("reset_clears_rdata", read_data, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check1("post_reset_resp", response, 1'b1);
      check32("post_reset_ctrl", read_data, 32'h0);
      read = 1'b0;
      @(posedge clk); #1;
      check1("post_reset_resp_end", response, 1'b0);
      @(posedge clk); #1;
      bus_access(1'b1, 1'b0, 3'd2, 32'h0, d);
      check32("post_reset_cmp_lo", d, 32'hFFFF_FFFF);
      bus_access(1'b1, 1'b0, 3'd3, 32'h0, d);
      check32("post_reset_cmp_hi", d, 32'hFFFF_FFFF);
      bus_access(1'b1, 1'b0, 3'd0, 32'h0, d);
      check32("post_reset_mtime", d, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
